// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-deep request/hold sequencer that owns the PC.
// Optional FETCH_COUNT_EN adds a 32-bit counter of accepted issue acknowledges.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        IssueAck,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        FetchFault
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] FetchCount
`endif
);

    // state | meaning
    // IDLE  | one bubble after reset, no request
    // FETCH | request outstanding at PC, waiting for ImemReady
    // HOLD  | instruction held for decode, waiting for IssueAck
    // FAULT | misaligned branch target seen, halted until reset
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        ack_hold;
    logic        target_misaligned;

    assign ack_hold          = (state == HOLD) && IssueAck;
    assign target_misaligned = PCSrc && (Result[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: if (ImemReady) state_nxt = HOLD;
            HOLD:  if (IssueAck) state_nxt = target_misaligned ? FAULT : FETCH;
            FAULT: state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ImemReq    = 1'b0;
        InstrValid = 1'b0;
        FetchFault = 1'b0;
        case (state)
            FETCH:   ImemReq    = 1'b1;
            HOLD:    InstrValid = 1'b1;
            FAULT:   FetchFault = 1'b1;
            default: ;
        endcase
    end

    // On a faulting branch the PC keeps the address of the offending instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            instr_q <= 32'h0000_0000;
        end else begin
            if ((state == FETCH) && ImemReady) begin
                instr_q <= ImemRdata;
            end
            if (ack_hold) begin
                if (!PCSrc) begin
                    pc_q <= pc_q + 32'd4;
                end else if (!target_misaligned) begin
                    pc_q <= Result;
                end
            end
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'h0000_0000;
        end else if (ack_hold && !target_misaligned) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign FetchCount = fetch_count_q;
`endif

    assign PC       = pc_q;
    assign ImemAddr = pc_q;
    assign Instr    = instr_q;
    assign PCPlus8  = pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus pushes {pc, instr} per memory
// response, and a negedge monitor pops on every new InstrValid assertion.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc;
    logic [31:0] Result;
    logic        IssueAck;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemRdata;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic        FetchFault;
`ifdef FETCH_COUNT_EN
    logic [31:0] FetchCount;
`endif

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrc      (PCSrc),
        .Result     (Result),
        .IssueAck   (IssueAck),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemReady  (ImemReady),
        .ImemRdata  (ImemRdata),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .PCPlus8    (PCPlus8),
        .FetchFault (FetchFault)
`ifdef FETCH_COUNT_EN
        ,
        .FetchCount (FetchCount)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: each rising edge of InstrValid must present the oldest expected entry.
    always @(negedge clk) begin
        if (InstrValid === 1'b1 && !prev_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got %h expected none", Instr);
            end else begin
                exp_e = exp_q.pop_front();
                chk("instr", Instr, exp_e[31:0]);
                chk("instr_pc", PC, exp_e[63:32]);
                chk("instr_pcplus8", PCPlus8, exp_e[63:32] + 32'd8);
            end
        end
        prev_valid = (InstrValid === 1'b1);
    end

    task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int wait_n);
        int t = 0;
        while (ImemReq !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk1("imem_req", ImemReq, 1'b1);
        chk("imem_addr", ImemAddr, pc);
        chk1("valid_in_fetch", InstrValid, 1'b0);
        repeat (wait_n) begin
            @(negedge clk);
            chk1("req_stable", ImemReq, 1'b1);
            chk("addr_stable", ImemAddr, pc);
        end
        ImemReady = 1'b1;
        ImemRdata = data;
        exp_q.push_back({pc, data});
        @(posedge clk);
        #1;
        ImemReady = 1'b0;
        ImemRdata = 32'hDEAD_BEEF;
    endtask

    task automatic ack(input logic src, input logic [31:0] res);
        logic [31:0] pc0;
        logic [31:0] i0;
        @(negedge clk);
        pc0 = PC;
        i0  = Instr;
        PCSrc    = 1'b1;
        Result   = 32'h0000_0200;
        IssueAck = 1'b0;
        ImemReady = 1'b1;
        @(negedge clk);
        ImemReady = 1'b0;
        chk1("hold_valid", InstrValid, 1'b1);
        chk1("hold_req", ImemReq, 1'b0);
        chk("hold_pc", PC, pc0);
        chk("hold_instr", Instr, i0);
        PCSrc    = src;
        Result   = res;
        IssueAck = 1'b1;
        @(posedge clk);
        #1;
        IssueAck = 1'b0;
        PCSrc    = 1'b0;
        Result   = 32'h0000_0000;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        reset     = 1'b1;
        PCSrc     = 1'b0;
        Result    = 32'h0;
        IssueAck  = 1'b0;
        ImemReady = 1'b0;
        ImemRdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_req", ImemReq, 1'b0);
        chk1("rst_valid", InstrValid, 1'b0);
        chk1("rst_fault", FetchFault, 1'b0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_addr", ImemAddr, 32'h0);
        chk("rst_pcplus8", PCPlus8, 32'h8);
`ifdef FETCH_COUNT_EN
        chk("rst_count", FetchCount, 32'h0);
`endif
        reset = 1'b0;

        fetch(32'h0000_0000, 32'hE3A0_1005, 1);
        ack(1'b0, 32'h0);
        chk("pc_inc", PC, 32'h0000_0004);
        fetch(32'h0000_0004, 32'hE081_2003, 0);
        ack(1'b1, 32'h0000_0010);
        chk("pc_branch", PC, 32'h0000_0010);
        fetch(32'h0000_0010, 32'hE591_2000, 0);
        ack(1'b0, 32'h0);
        chk("pc_14", PC, 32'h0000_0014);
        chk("addr_14", ImemAddr, 32'h0000_0014);
        chk("pcplus8_1c", PCPlus8, 32'h0000_001C);
        fetch(32'h0000_0014, 32'hEAFF_FFFE, 2);
        ack(1'b1, 32'h0000_0100);
        fetch(32'h0000_0100, 32'hE1A0_0000, 0);
        ack(1'b1, 32'hFFFF_FFFC);
        chk("pcplus8_wrap", PCPlus8, 32'h0000_0004);
        fetch(32'hFFFF_FFFC, 32'hE3A0_0001, 5);
        ack(1'b0, 32'h0);
        chk("pc_wrap", PC, 32'h0000_0000);
        chk("pcplus8_after_wrap", PCPlus8, 32'h0000_0008);
        fetch(32'h0000_0000, 32'hE280_0001, 0);
        ack(1'b1, 32'h0000_0102);
        IssueAck  = 1'b1;
        ImemReady = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk1("fault_flag", FetchFault, 1'b1);
            chk1("fault_req", ImemReq, 1'b0);
            chk1("fault_valid", InstrValid, 1'b0);
            chk("fault_pc", PC, 32'h0000_0000);
        end
        IssueAck  = 1'b0;
        ImemReady = 1'b0;

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
        while (ImemReq !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk1("refetch_req", ImemReq, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        ImemReady = 1'b1;
        ImemRdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        ImemReady = 1'b0;
        chk("late_ready_instr", Instr, 32'h0);
        chk1("late_ready_valid", InstrValid, 1'b0);
        chk("late_ready_pc", PC, 32'h0);
        chk1("late_ready_fault", FetchFault, 1'b0);

        for (int i = 0; i < 3; i++) begin
            fetch(32'(i * 4), 32'hE280_0010 + 32'(i), 0);
            ack(1'b0, 32'h0);
        end
        @(negedge clk);
        chk("pc_after_three", PC, 32'h0000_000C);
`ifdef FETCH_COUNT_EN
        chk("fetch_count", FetchCount, 32'd3);
`endif
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
